// File: rtl/w1_loader.sv
// Weight sequencer for conv layer 1: sweeps the w1 ROM once per request and keeps
// the six per-channel weights of every tap in a local buffer with a zero-latency read port.
module w1_loader #(
    parameter int KERNEL_TAPS = 25,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int ROM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    output logic              load_busy,
    output logic              load_done,
    output logic              weights_ready,
    output logic [ADDR_W-1:0] w1_raddr,
    input  logic [DATA_W-1:0] w1_1_rdata,
    input  logic [DATA_W-1:0] w1_2_rdata,
    input  logic [DATA_W-1:0] w1_3_rdata,
    input  logic [DATA_W-1:0] w1_4_rdata,
    input  logic [DATA_W-1:0] w1_5_rdata,
    input  logic [DATA_W-1:0] w1_6_rdata,
    input  logic [ADDR_W-1:0] k_raddr,
    output logic [DATA_W-1:0] k_1_rdata,
    output logic [DATA_W-1:0] k_2_rdata,
    output logic [DATA_W-1:0] k_3_rdata,
    output logic [DATA_W-1:0] k_4_rdata,
    output logic [DATA_W-1:0] k_5_rdata,
    output logic [DATA_W-1:0] k_6_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(KERNEL_TAPS - 1);
    localparam logic [ADDR_W:0]   TAP_COUNT = (ADDR_W + 1)'(KERNEL_TAPS);

    state_t                state_r;
    logic [6*DATA_W-1:0]   wbuf_r [KERNEL_TAPS];
    logic                  pipe_valid_r [ROM_LAT];
    logic [ADDR_W-1:0]     pipe_tap_r [ROM_LAT];

    logic                  cap_valid_s;
    logic [ADDR_W-1:0]     cap_tap_s;
    logic [6*DATA_W-1:0]   rom_word_s;
    logic [6*DATA_W-1:0]   rd_word_s;

    // The tail of the (valid, tap) pipeline lines up with the ROM data of that tap.
    assign cap_valid_s = pipe_valid_r[ROM_LAT-1];
    assign cap_tap_s   = pipe_tap_r[ROM_LAT-1];
    assign rom_word_s  = {w1_6_rdata, w1_5_rdata, w1_4_rdata,
                          w1_3_rdata, w1_2_rdata, w1_1_rdata};

    // Sequencer FSM; w1_raddr doubles as the tap counter during FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            w1_raddr      <= '0;
            load_busy     <= 1'b0;
            load_done     <= 1'b0;
            weights_ready <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    w1_raddr  <= '0;
                    load_done <= 1'b0;
                    if (load_start) begin
                        state_r       <= S_FETCH;
                        load_busy     <= 1'b1;
                        weights_ready <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (w1_raddr == LAST_TAP) begin
                        w1_raddr <= '0;
                        state_r  <= S_DRAIN;
                    end else begin
                        w1_raddr <= w1_raddr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Leave once the final tap is being written, i.e. after ROM_LAT cycles.
                    if (cap_valid_s && (cap_tap_s == LAST_TAP)) begin
                        state_r       <= S_DONE;
                        load_busy     <= 1'b0;
                        load_done     <= 1'b1;
                        weights_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    load_done <= 1'b0;
                    state_r   <= S_IDLE;
                end
                default: begin
                    state_r   <= S_IDLE;
                    w1_raddr  <= '0;
                    load_busy <= 1'b0;
                    load_done <= 1'b0;
                end
            endcase
        end
    end

    // Delay line carrying (valid, tap) alongside each issued ROM address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ROM_LAT; k++) begin
                pipe_valid_r[k] <= 1'b0;
                pipe_tap_r[k]   <= '0;
            end
        end else begin
            pipe_valid_r[0] <= (state_r == S_FETCH);
            pipe_tap_r[0]   <= w1_raddr;
            for (int k = 1; k < ROM_LAT; k++) begin
                pipe_valid_r[k] <= pipe_valid_r[k-1];
                pipe_tap_r[k]   <= pipe_tap_r[k-1];
            end
        end
    end

    // Weight buffer: cleared on reset, one tap written per valid pipeline output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < KERNEL_TAPS; t++) begin
                wbuf_r[t] <= '0;
            end
        end else if (cap_valid_s) begin
            wbuf_r[cap_tap_s] <= rom_word_s;
        end
    end

    // Combinational tap read; addresses beyond the kernel read as zero.
    always_comb begin
        rd_word_s = '0;
        if ({1'b0, k_raddr} < TAP_COUNT) begin
            rd_word_s = wbuf_r[k_raddr];
        end else begin
            rd_word_s = '0;
        end
    end

    assign k_1_rdata = rd_word_s[0*DATA_W +: DATA_W];
    assign k_2_rdata = rd_word_s[1*DATA_W +: DATA_W];
    assign k_3_rdata = rd_word_s[2*DATA_W +: DATA_W];
    assign k_4_rdata = rd_word_s[3*DATA_W +: DATA_W];
    assign k_5_rdata = rd_word_s[4*DATA_W +: DATA_W];
    assign k_6_rdata = rd_word_s[5*DATA_W +: DATA_W];

endmodule

// File: tb/tb_w1_loader.sv
// Scoreboard bench for w1_loader: one instance with ROM_LAT=1, one with ROM_LAT=2,
// each fed by a behavioural registered ROM.
module tb_w1_loader;

    logic       clk;
    logic       rst;
    logic       load_start1, load_start2;
    logic [4:0] k_raddr;
    logic       rom_mode;
    int         cyc;
    int         n_vec;
    int         n_err;
    bit         mon_en;

    logic       busy1, done1, ready1, busy2, done2, ready2;
    logic [4:0] raddr1, raddr2;
    logic [7:0] rom1_q [6];
    logic [7:0] rom2a_q [6];
    logic [7:0] rom2b_q [6];
    logic [7:0] k1 [6];
    logic [7:0] k2 [6];

    typedef struct {
        int cyc;
        int addr;
    } aexp_t;

    aexp_t addr_q [$];
    int    done1_q [$];
    int    done2_q [$];

    w1_loader #(.KERNEL_TAPS(25), .ADDR_W(5), .DATA_W(8), .ROM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .load_start(load_start1),
        .load_busy(busy1), .load_done(done1), .weights_ready(ready1),
        .w1_raddr(raddr1),
        .w1_1_rdata(rom1_q[0]), .w1_2_rdata(rom1_q[1]), .w1_3_rdata(rom1_q[2]),
        .w1_4_rdata(rom1_q[3]), .w1_5_rdata(rom1_q[4]), .w1_6_rdata(rom1_q[5]),
        .k_raddr(k_raddr),
        .k_1_rdata(k1[0]), .k_2_rdata(k1[1]), .k_3_rdata(k1[2]),
        .k_4_rdata(k1[3]), .k_5_rdata(k1[4]), .k_6_rdata(k1[5])
    );

    w1_loader #(.KERNEL_TAPS(25), .ADDR_W(5), .DATA_W(8), .ROM_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .load_start(load_start2),
        .load_busy(busy2), .load_done(done2), .weights_ready(ready2),
        .w1_raddr(raddr2),
        .w1_1_rdata(rom2b_q[0]), .w1_2_rdata(rom2b_q[1]), .w1_3_rdata(rom2b_q[2]),
        .w1_4_rdata(rom2b_q[3]), .w1_5_rdata(rom2b_q[4]), .w1_6_rdata(rom2b_q[5]),
        .k_raddr(k_raddr),
        .k_1_rdata(k2[0]), .k_2_rdata(k2[1]), .k_3_rdata(k2[2]),
        .k_4_rdata(k2[3]), .k_5_rdata(k2[4]), .k_6_rdata(k2[5])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_byte(input logic [4:0] addr, input int ch);
        rom_byte = rom_mode ? 8'hA5 : 8'(int'(addr) + ch * 32);
    endfunction

    // Registered ROM models: one stage for dut1, two stages for dut2.
    always @(posedge clk) begin
        for (int ch = 0; ch < 6; ch++) begin
            rom1_q[ch]  <= rom_byte(raddr1, ch);
            rom2a_q[ch] <= rom_byte(raddr2, ch);
            rom2b_q[ch] <= rom2a_q[ch];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // mode 0: addr+ch*32, mode 1: all A5, mode 2: all zero
    function automatic logic [47:0] exp_word(input int mode, input int t);
        logic [47:0] w;
        w = '0;
        for (int ch = 0; ch < 6; ch++) begin
            if (t >= 25 || mode == 2) w[ch*8 +: 8] = 8'h00;
            else if (mode == 1)       w[ch*8 +: 8] = 8'hA5;
            else                      w[ch*8 +: 8] = 8'(t + ch * 32);
        end
        return w;
    endfunction

    task automatic check_buf(input bit which, input int mode);
        logic [47:0] got;
        for (int t = 0; t < 32; t++) begin
            k_raddr = 5'(t);
            #1;
            if (which) got = {k2[5], k2[4], k2[3], k2[2], k2[1], k2[0]};
            else       got = {k1[5], k1[4], k1[3], k1[2], k1[1], k1[0]};
            check(which ? "buf2" : "buf1", got, exp_word(mode, t));
        end
    endtask

    // Monitor: address sweep and load_done pulses popped from the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
                aexp_t e;
                e = addr_q.pop_front();
                check("raddr1", raddr1, e.addr);
            end else begin
                check("raddr1_idle", raddr1, 0);
            end
            if (done1) begin
                if (done1_q.size() == 0) check("done1_spurious", 1, 0);
                else check("done1_cycle", cyc, done1_q.pop_front());
            end
            if (done2) begin
                if (done2_q.size() == 0) check("done2_spurious", 1, 0);
                else check("done2_cycle", cyc, done2_q.pop_front());
            end
        end
    end

    task automatic start_load1(output int t0);
        @(posedge clk); #1;
        t0 = cyc;
        load_start1 = 1'b1;
        for (int i = 0; i < 25; i++) addr_q.push_back('{t0 + 1 + i, i});
        done1_q.push_back(t0 + 27);
    endtask

    task automatic run_load1(input int ign_a, input int ign_b);
        int t0;
        start_load1(t0);
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            load_start1 = (c == ign_a || c == ign_b);
            @(negedge clk);
            check("ready1", ready1, (c >= 27));
            check("busy1", busy1, (c <= 26));
        end
        load_start1 = 1'b0;
    endtask

    initial begin
        int t0;
        n_vec = 0; n_err = 0; mon_en = 1'b0; cyc = 0;
        rst = 1'b1; load_start1 = 1'b0; load_start2 = 1'b0; k_raddr = '0; rom_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Reset then idle
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_ready", ready1, 0);
        check("rst_ready2", ready2, 0);
        check_buf(1'b0, 2);
        check_buf(1'b1, 2);

        // Single load with ignored starts at T+5 and T+26
        run_load1(5, 26);
        k_raddr = 5'd7;
        #1;
        check("k7_ch1", k1[0], 8'd7);
        check("k7_ch6", k1[5], 8'd167);
        check_buf(1'b0, 0);

        // Reload with new ROM contents
        rom_mode = 1'b1;
        run_load1(-1, -1);
        check_buf(1'b0, 1);

        // Mid-load reset at T+12
        rom_mode = 1'b0;
        start_load1(t0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            load_start1 = 1'b0;
        end
        rst = 1'b1;
        addr_q.delete();
        done1_q.delete();
        #1;
        check("mid_rst_raddr", raddr1, 0);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_done", done1, 0);
        check("mid_rst_ready", ready1, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_buf(1'b0, 2);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", ready1, 0);

        // ROM_LAT=2 instance, load_start held high for two back-to-back loads
        @(posedge clk); #1;
        t0 = cyc;
        load_start2 = 1'b1;
        done2_q.push_back(t0 + 28);
        done2_q.push_back(t0 + 57);
        for (int c = 1; c <= 62; c++) begin
            @(posedge clk); #1;
            if (c == 57) load_start2 = 1'b0;
            @(negedge clk);
            check("ready2", ready2, ((c >= 28 && c <= 29) || c >= 57));
        end
        check_buf(1'b1, 0);

        check("done1_missing", done1_q.size(), 0);
        check("done2_missing", done2_q.size(), 0);
        check("addr_missing", addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/w1_loader.md
Name: w1_loader

Overview:
- Sequencer and local weight buffer for conv layer1.
- Sits directly upstream of the conv1 PE array.
- On request it walks the w1 weight ROM addresses 0..KERNEL_TAPS-1 and absorbs the ROM's registered read latency. It captures the six 8-bit per-channel weights of every tap into an internal register file.
- The conv engine then reads any tap through a single-cycle combinational read port, with no ROM latency.

Parameters:
- KERNEL_TAPS, 25, taps per 5x5 kernel; legal range 1..2^ADDR_W.
- ADDR_W, 5, width of the ROM address and the tap read address.
- DATA_W, 8, width of one channel weight.
- ROM_LAT, 1, clock cycles from the w1_raddr edge to valid ROM data; legal range 1..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_start  input  1  request a full weight load; sampled only in IDLE.
- load_busy  output  1  high while in FETCH or DRAIN.
- load_done  output  1  one-cycle pulse when the last tap has been written.
- weights_ready  output  1  level; buffer holds a complete, consistent weight set.
- w1_raddr  output  ADDR_W  address to the w1 ROM.
- w1_1_rdata..w1_6_rdata  input  DATA_W each  channel 1..6 weight from the ROM.
- k_raddr  input  ADDR_W  conv-engine tap select.
- k_1_rdata..k_6_rdata  output  DATA_W each  stored channel 1..6 weight of tap k_raddr; combinational from the buffer.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - w1_raddr=0, load_busy=0, load_done=0, weights_ready=0.
  - Tap counter=0, valid pipeline cleared.
  - All buffer entries cleared to 0, so k_*_rdata=0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - w1_raddr held at 0.
  - load_start=1 -> FETCH next cycle, and weights_ready clears that same edge.
- FETCH:
  - One address per cycle: w1_raddr = 0,1,...,KERNEL_TAPS-1 on consecutive cycles.
  - A ROM_LAT-deep pipeline carries (valid, tap index) alongside each issued address.
  - After KERNEL_TAPS-1 is issued -> DRAIN.
- Capture:
  - When the pipeline output is valid, the edge writes w1_n_rdata into buffer[tap][n] for n=1..6.
  - Pipelined capture is active in both FETCH and DRAIN.
- DRAIN:
  - w1_raddr returns to 0.
  - Lasts exactly ROM_LAT cycles, until the last tap is written -> DONE.
- DONE:
  - Single cycle, in which load_done=1 and weights_ready goes to 1 (registered, stays high).
  - -> IDLE.
- Timing, with F0 = first FETCH cycle (cycle after load_start is sampled):
  - Tap i is written at the end of cycle F0+i+ROM_LAT.
  - load_done is high in cycle F0+KERNEL_TAPS+ROM_LAT.
  - Default end-to-end: load_start sampled in cycle T -> load_done in cycle T+27.
- load_start while busy or in DONE: ignored, no queuing.
- load_start held high continuously: a new load starts on every return to IDLE, i.e. back-to-back loads separated by one IDLE cycle.
- Read port:
  - Always live.
  - During a load, the entries not yet rewritten return their old values; consumers qualify reads with weights_ready.
  - k_raddr >= KERNEL_TAPS returns 0.
- Reset mid-load: immediate abort, all outputs to their reset values, partially loaded data discarded (cleared).
- No arithmetic; data is passed through bit-exact, with no sign handling.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst, release, wait 10 cycles, no load_start.
  - Required: w1_raddr=0, busy=0, done=0, ready=0, k_1..6_rdata=0 for all k_raddr.
- Single load, ROM model with ROM_LAT=1 returning {6{addr+ch*32}}:
  - Stimulus: load_start pulse in cycle T.
  - Required: w1_raddr 0..24 on cycles T+1..T+25; load_done exactly in cycle T+27; ready=1 from T+27.
  - Required: k_raddr=7 gives k_1=7, k_6=167.
- Start ignored while busy:
  - Stimulus: second load_start pulses at T+5 and T+26.
  - Required: no extra address sweep; a single load_done at T+27.
- Reload:
  - Stimulus: after a completed load, change the ROM contents to {6{8'hA5}} and pulse load_start.
  - Required: ready drops the next cycle; done after 27 cycles; all 25 taps read A5 on every channel.
- Mid-load reset:
  - Stimulus: assert rst at T+12.
  - Required: outputs immediately at reset values; buffer reads 0 for taps 0..10; no load_done afterwards.
- Latency parameter:
  - Stimulus: ROM_LAT=2 with a ROM model delayed by 2 cycles.
  - Required: load_done at T+28; captured data is correct per tap with no off-by-one.
  - Required: k_raddr=25..31 reads 0.
